btn_digit_entry: RTL
====================

Name: btn_digit_entry

Overview:
Parametrised keypad-style digit entry from five push-buttons. Raw buttons are synchronised and debounced. Left/right moves a digit cursor, and up/down edits the selected digit, with optional auto-repeat while held. Centre commits the value; holding centre clears it. Sits between the board buttons and the ATM transaction/display logic. Generalises the existing fixed 8-digit hex entry block with digit count, radix, hold-repeat, commit and lock.

Parameters:
NUM_DIGITS, 8, number of 4-bit digits (2..16); SEL_W = max(1, clog2(NUM_DIGITS)) is a derived localparam
RADIX_BCD, 1, 1 = digits 0..9 (BCD), 0 = digits 0..15 (hex)
DB_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its debounced level before that level flips
REPEAT_DELAY, 25000000, cycles up/down must stay held before auto-repeat starts; 0 disables repeat
REPEAT_RATE, 5000000, cycles between repeat events (>=1)
CLEAR_HOLD, 100000000, cycles centre must stay held to trigger clear (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous and active-high
btn_i  in  5  raw buttons: [0]=up [1]=down [2]=left [3]=right [4]=centre
lock_i  in  1  1 = edits and commit ignored (debounce keeps running)
data_o  out  4*NUM_DIGITS  current entry; digit k = data_o[4k+3:4k]
sel_o  out  SEL_W  cursor index, 0 = least significant digit
commit_o  out  1  one-cycle pulse on commit
commit_data_o  out  4*NUM_DIGITS  value captured at the last commit
clear_o  out  1  one-cycle pulse on hold-clear

Behaviour:
- Reset (async assert, sync release): data_o=0, sel_o=0, commit_o=0, commit_data_o=0, clear_o=0. Debounced levels and all counters are 0, and the centre FSM is in IDLE.
- Per button: 2-FF synchroniser, then a debounce counter that increments while the synced value differs from the debounced level and resets to 0 when they match.
  - The debounced level flips on the edge where the counter would reach DB_CYCLES.
- Press event: registered rising edge of the debounced level, one cycle wide.
- Edit/commit outputs are registered. The output changes exactly DB_CYCLES+4 edges after the first edge sampling the new raw level. The bench checks this latency exactly.
- Per-cycle action priority, at most one action per cycle:
  1. clear
  2. centre press
  3. left/right
  4. up/down
  - Lower-priority events in the same cycle are dropped, not queued.
  - Left and right pressed together: no action. Up and down pressed together: no action.
- Left: sel_o+1, wrapping NUM_DIGITS-1 -> 0. Right: sel_o-1, wrapping 0 -> NUM_DIGITS-1.
- Up: selected digit +1, wrapping DMAX -> 0. Down: selected digit -1, wrapping 0 -> DMAX. DMAX = 9 if RADIX_BCD, else 15. Other digits are unchanged.
- Auto-repeat (REPEAT_DELAY>0): while exactly one of up/down is debounced-high, a hold counter runs from the press event.
  - First repeat event after REPEAT_DELAY cycles, then one every REPEAT_RATE cycles.
  - Release or a change of direction stops repeat and zeroes the counter.
  - Repeat events are treated exactly like presses.
- Centre FSM: IDLE --press--> HELD. HELD --release--> IDLE. HELD --held CLEAR_HOLD cycles--> CLEARED. CLEARED --release--> IDLE.
  - On the press (IDLE->HELD): commit_o=1 for one cycle and commit_data_o<=data_o, using the value before any same-cycle edit.
  - On HELD->CLEARED: clear_o=1 for one cycle, data_o<=0, sel_o<=0. commit_data_o is unchanged.
- lock_i=1: press/repeat/commit actions are suppressed and outputs hold. The centre FSM still tracks the button, but commit and clear pulses are masked. lock_i is sampled directly and must be synchronous to clk.
- Reset mid-hold or mid-debounce returns everything to reset values; no pulse is emitted during or after reset.
- Hex mode with a BCD-invalid value: no special handling. In BCD mode, digits never exceed 9 because only edits write them.

Test Plan:
(Bench parameters: NUM_DIGITS=4, RADIX_BCD=1, DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3, CLEAR_HOLD=20.)
1. Debounce: glitch btn_i[0] high for 3 cycles -> data_o stays 16'h0000. Hold it high 10 cycles -> data_o=16'h0001 exactly 8 edges after the first high sample.
2. Wrap: 10 up presses on digit 0 -> 16'h0000. One down -> 16'h0009. Right from sel 0 -> sel_o=3. Then up -> 16'h1009.
3. Auto-repeat: hold up 20 cycles past its press event -> press plus repeats at +8, +11, +14, +17 -> digit 0 = 5.
4. Commit/clear: enter 16'h0042, then tap centre -> commit_o 1 cycle, commit_data_o=16'h0042. Hold centre 25 cycles -> clear_o pulse, data_o=0, sel_o=0, commit_data_o still 16'h0042.
5. Priority and lock: centre and left pressed in the same cycle -> commit only, sel unchanged. lock_i=1 with up pressed -> data_o unchanged, no pulses.
6. Async reset asserted mid-hold of up with data 16'h0305 -> all outputs 0 immediately. Button still high after release -> no event until the debounced level is re-observed rising.

Source files
------------

// File: rtl/btn_digit_entry.sv
// Five-button digit entry: synchronise and debounce the buttons, move a cursor,
// edit the selected digit with hold-repeat, commit on centre, clear on long centre hold.
module btn_digit_entry #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned RADIX_BCD    = 1,
  parameter int unsigned DB_CYCLES    = 1000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned CLEAR_HOLD   = 100000000,
  localparam int unsigned SEL_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              btn_i,
  input  logic                    lock_i,
  output logic [4*NUM_DIGITS-1:0] data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    commit_o,
  output logic [4*NUM_DIGITS-1:0] commit_data_o,
  output logic                    clear_o
);

  localparam int unsigned DW      = 4 * NUM_DIGITS;
  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam int unsigned CLR_W   = $clog2(CLEAR_HOLD + 1);
  localparam bit          REP_EN  = (REPEAT_DELAY != 0);
  localparam logic [3:0]  DMAX    = (RADIX_BCD != 0) ? 4'd9 : 4'd15;

  typedef enum logic [1:0] {C_IDLE, C_HELD, C_CLEARED} c_state_t;

  logic [4:0]      sync1, sync2, db, db_q, press;
  logic [DB_W-1:0] db_cnt [5];

  // Synchroniser, debounce counter and one-cycle press detect per button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
      db_q  <= db;
      press <= db & ~db_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db[i]     <= ~db[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic             rep_act, rep_dir, rep_phase;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_start, rep_hold, rep_ev;

  // rep_dir: 0 = up, 1 = down; repeat only while exactly one of up/down is held
  always_comb begin
    rep_start = REP_EN && ((press[0] && !db[1]) || (press[1] && !db[0]));
    rep_hold  = rep_act && (db[0] ^ db[1]) && (db[1] == rep_dir);
    rep_ev    = rep_hold && (rep_phase ? (rep_cnt == REP_W'(REPEAT_RATE))
                                       : (rep_cnt == REP_W'(REPEAT_DELAY)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_act   <= 1'b0;
      rep_dir   <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_start) begin
      rep_act   <= 1'b1;
      rep_dir   <= press[1];
      rep_phase <= 1'b0;
      rep_cnt   <= REP_W'(1);
    end else if (!rep_hold) begin
      rep_act   <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_ev) begin
      rep_phase <= 1'b1;
      rep_cnt   <= REP_W'(1);
    end else begin
      rep_cnt   <= rep_cnt + REP_W'(1);
    end
  end

  c_state_t         c_state, c_next;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_next;
  logic             commit_ev, clear_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state <= C_IDLE;
      clr_cnt <= '0;
    end else begin
      c_state <= c_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Centre button: commit on press, clear after a long uninterrupted hold
  always_comb begin
    c_next       = c_state;
    clr_cnt_next = clr_cnt;
    commit_ev    = 1'b0;
    clear_ev     = 1'b0;
    case (c_state)
      C_IDLE: begin
        clr_cnt_next = '0;
        if (press[4]) begin
          c_next    = C_HELD;
          commit_ev = 1'b1;
        end
      end
      C_HELD: begin
        if (!db[4]) begin
          c_next       = C_IDLE;
          clr_cnt_next = '0;
        end else if (clr_cnt == CLR_W'(CLEAR_HOLD - 1)) begin
          c_next       = C_CLEARED;
          clear_ev     = 1'b1;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + CLR_W'(1);
        end
      end
      C_CLEARED: if (!db[4]) c_next = C_IDLE;
      default:   c_next = C_IDLE;
    endcase
  end

  logic             ev_up, ev_dn, ev_lr;
  logic [3:0]       cur_digit, new_digit;
  logic [DW-1:0]    data_edit;
  logic [SEL_W-1:0] sel_left, sel_right;

  always_comb begin
    ev_up     = press[0] | (rep_ev & ~rep_dir);
    ev_dn     = press[1] | (rep_ev & rep_dir);
    ev_lr     = press[2] | press[3];
    cur_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (SEL_W'(k) == sel_o) cur_digit = data_o[4*k +: 4];
    if (ev_up) new_digit = (cur_digit == DMAX) ? 4'd0 : cur_digit + 4'd1;
    else       new_digit = (cur_digit == 4'd0) ? DMAX : cur_digit - 4'd1;
    data_edit = data_o;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (SEL_W'(k) == sel_o) data_edit[4*k +: 4] = new_digit;
    sel_left  = (sel_o == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_o + SEL_W'(1);
    sel_right = (sel_o == '0) ? SEL_W'(NUM_DIGITS - 1) : sel_o - SEL_W'(1);
  end

  // One prioritised action per cycle; a consumed higher-priority event drops the rest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o        <= '0;
      sel_o         <= '0;
      commit_o      <= 1'b0;
      commit_data_o <= '0;
      clear_o       <= 1'b0;
    end else begin
      commit_o <= 1'b0;
      clear_o  <= 1'b0;
      if (!lock_i) begin
        if (clear_ev) begin
          data_o  <= '0;
          sel_o   <= '0;
          clear_o <= 1'b1;
        end else if (commit_ev) begin
          commit_o      <= 1'b1;
          commit_data_o <= data_o;
        end else if (ev_lr) begin
          if (press[2] && !press[3]) sel_o <= sel_left;
          if (press[3] && !press[2]) sel_o <= sel_right;
        end else if (ev_up ^ ev_dn) begin
          data_o <= data_edit;
        end
      end
    end
  end

endmodule
